// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Deterministic rate-coding spike generator. Each channel holds an
//   intensity value. On every enabled RUN step, that value is added into a
//   VAL_W-bit accumulator. The carry-out of that addition is the channel's
//   spike for the step. Over 2^VAL_W steps, starting from a cleared
//   accumulator, a channel therefore fires exactly `value` times.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   enable      step advance gate in RUN (low = stall)
//   load        captures `values` into the intensity registers (IDLE/DONE only)
//   values      channel i intensity at bits [i*VAL_W +: VAL_W]
//   window_len  steps per window, sampled on start
//   start       begins a window (IDLE/DONE only)
//   busy        high while in RUN
//   done        high while in DONE
//   spikes_out  registered 1-cycle spike pulses, one bit per channel
//   step_count  steps completed in the current or last window
module spike_rate_encoder #(
   parameter int CHANNELS = 8,
   parameter int VAL_W    = 4,
   parameter int WIN_W    = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      load,
   input  logic [CHANNELS*VAL_W-1:0] values,
   input  logic [WIN_W-1:0]          window_len,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [CHANNELS-1:0]       spikes_out,
   output logic [WIN_W-1:0]          step_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [VAL_W-1:0]  intensity [CHANNELS];
   logic [VAL_W-1:0]  acc       [CHANNELS];
   logic [VAL_W:0]    sum       [CHANNELS];
   logic [WIN_W-1:0]  win_len;
   logic [WIN_W-1:0]  step_next;

   // One accumulation step, one bit wider than the operands so the MSB is
   // the carry-out that becomes the spike.
   function automatic logic [VAL_W:0] acc_step(input logic [VAL_W-1:0] a,
                                               input logic [VAL_W-1:0] v);
      return {1'b0, a} + {1'b0, v};
   endfunction

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         sum[i] = acc_step(acc[i], intensity[i]);
      end
   end

   assign step_next = step_count + WIN_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         spikes_out <= '0;
         step_count <= '0;
         win_len    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i]       <= '0;
            intensity[i] <= '0;
         end
      end else begin
         // Any edge that is not an enabled RUN step clears the spike
         // vector, which keeps every pulse exactly one cycle wide.
         spikes_out <= '0;
         case (state)
            IDLE, DONE: begin
               if (load) begin
                  for (int i = 0; i < CHANNELS; i++) begin
                     intensity[i] <= values[i*VAL_W +: VAL_W];
                  end
               end
               if (start) begin
                  win_len    <= window_len;
                  step_count <= '0;
                  for (int i = 0; i < CHANNELS; i++) begin
                     acc[i] <= '0;
                  end
                  if (window_len == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (enable) begin
                  for (int i = 0; i < CHANNELS; i++) begin
                     spikes_out[i] <= sum[i][VAL_W];
                     acc[i]        <= sum[i][VAL_W-1:0];
                  end
                  step_count <= step_next;
                  if (step_next == win_len) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [31:0] values;
   logic [4:0]  window_len;
   logic        start;
   logic        busy;
   logic        done;
   logic [7:0]  spikes_out;
   logic [4:0]  step_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Hand-derived spike masks over a 16-step window, bit k = step k.
   logic [15:0] m_v4;   // value 4 : steps 3,7,11,15
   logic [15:0] m_v8;   // value 8 : odd steps
   logic [15:0] m_v15;  // value 15: steps 1..15
   logic [15:0] m_zero;

   spike_rate_encoder #(.CHANNELS(8), .VAL_W(4), .WIN_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .values     (values),
      .window_len (window_len),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .spikes_out (spikes_out),
      .step_count (step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic b, input logic d,
                           input logic [7:0] sp, input logic [4:0] sc);
      chk({tag, " busy"},  {31'd0, busy}, {31'd0, b});
      chk({tag, " done"},  {31'd0, done}, {31'd0, d});
      chk({tag, " spikes"}, {24'd0, spikes_out}, {24'd0, sp});
      chk({tag, " step_count"}, {27'd0, step_count}, {27'd0, sc});
   endtask

   // Run steps k0..k1 of a window whose final step is `last`; after each
   // step edge check spikes for channels 0..3 against the masks.
   task automatic run_steps(input string tag, input int k0, input int k1, input int last,
                            input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
      logic [7:0] sp;
      for (int k = k0; k <= k1; k++) begin
         tick();
         sp = {4'b0000, c3[k], c2[k], c1[k], c0[k]};
         chk_outs($sformatf("%s step%0d", tag, k), (k != last), (k == last), sp, 5'(k + 1));
      end
   endtask

   initial begin
      m_v4   = 16'h8888;
      m_v8   = 16'hAAAA;
      m_v15  = 16'hFFFE;
      m_zero = 16'h0000;

      // Reset held two cycles with start and load asserted.
      rst_n      = 1'b0;
      enable     = 1'b1;
      load       = 1'b1;
      start      = 1'b1;
      values     = 32'hFFFF_FFFF;
      window_len = 5'd16;
      tick();
      chk_outs("reset c1", 1'b0, 1'b0, 8'h00, 5'd0);
      tick();
      chk_outs("reset c2", 1'b0, 1'b0, 8'h00, 5'd0);
      rst_n = 1'b1;
      load  = 1'b0;
      start = 1'b0;
      tick();
      chk_outs("post reset", 1'b0, 1'b0, 8'h00, 5'd0);
      tick();
      chk_outs("post reset idle", 1'b0, 1'b0, 8'h00, 5'd0);

      // Four channels 4, 8, 15, 0 over a 16-step window, load with start.
      values     = 32'h0000_0F84;
      window_len = 5'd16;
      load       = 1'b1;
      start      = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      chk_outs("win16 T+1", 1'b1, 1'b0, 8'h00, 5'd0);
      run_steps("win16", 0, 15, 15, m_v4, m_v8, m_v15, m_zero);
      tick();
      chk_outs("win16 T+18", 1'b0, 1'b1, 8'h00, 5'd16);

      // Zero-length window.
      window_len = 5'd0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk_outs("n0 T+1", 1'b0, 1'b1, 8'h00, 5'd0);
      tick();
      chk_outs("n0 T+2", 1'b0, 1'b1, 8'h00, 5'd0);

      // Stall of 3 cycles after step 5 with ch0=8.
      values     = 32'h0000_0008;
      window_len = 5'd16;
      load       = 1'b1;
      start      = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      chk_outs("stall T+1", 1'b1, 1'b0, 8'h00, 5'd0);
      run_steps("stall pre", 0, 5, 15, m_v8, m_zero, m_zero, m_zero);
      enable = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk_outs($sformatf("stall hold%0d", s), 1'b1, 1'b0, 8'h00, 5'd6);
      end
      enable = 1'b1;
      run_steps("stall post", 6, 15, 15, m_v8, m_zero, m_zero, m_zero);
      tick();
      chk_outs("stall after", 1'b0, 1'b1, 8'h00, 5'd16);

      // load + start during RUN are ignored (6-step window, ch0=4).
      values     = 32'h0000_0004;
      window_len = 5'd6;
      load       = 1'b1;
      start      = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      chk_outs("ign T+1", 1'b1, 1'b0, 8'h00, 5'd0);
      run_steps("ign pre", 0, 2, 5, m_v4, m_zero, m_zero, m_zero);
      values     = 32'hFFFF_FFFF;
      window_len = 5'd3;
      load       = 1'b1;
      start      = 1'b1;
      run_steps("ign inj", 3, 3, 5, m_v4, m_zero, m_zero, m_zero);
      load  = 1'b0;
      start = 1'b0;
      run_steps("ign post", 4, 5, 5, m_v4, m_zero, m_zero, m_zero);

      // Restart from DONE: accumulators hold 8 here, so a cleared restart
      // must reproduce steps 3,7,11,15 rather than 1,5,9,13.
      window_len = 5'd16;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk_outs("restart T+1", 1'b1, 1'b0, 8'h00, 5'd0);
      run_steps("restart", 0, 15, 15, m_v4, m_zero, m_zero, m_zero);

      // Reset at step 7 of a 16-step window.
      values     = 32'h0000_0004;
      window_len = 5'd16;
      load       = 1'b1;
      start      = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      run_steps("rst pre", 0, 6, 15, m_v4, m_zero, m_zero, m_zero);
      rst_n = 1'b0;
      tick();
      chk_outs("rst mid", 1'b0, 1'b0, 8'h00, 5'd0);
      rst_n = 1'b1;
      tick();
      chk_outs("rst after", 1'b0, 1'b0, 8'h00, 5'd0);
      load  = 1'b1;
      start = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      chk_outs("rst rerun T+1", 1'b1, 1'b0, 8'h00, 5'd0);
      run_steps("rst rerun", 0, 15, 15, m_v4, m_zero, m_zero, m_zero);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
